// File: rtl/clk_pattern_pkg.sv
// rtl/clk_pattern_pkg.sv - shared types, defaults and config check for clk_pattern_gen
package clk_pattern_pkg;

    localparam int CFG_W        = 16;
    localparam int DEF_PERIOD_C = 10;
    localparam int DEF_HIGH_C   = 5;
    localparam int DEF_PHASE_C  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    typedef struct packed {
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] high;
        logic [CFG_W-1:0] phase;
    } cfg_t;

    // high <= period-1 and phase <= period-1 written as strict compares to avoid underflow
    function automatic logic cfg_valid(input cfg_t c);
        return (c.period >= CFG_W'(2)) && (c.high >= CFG_W'(1)) &&
               (c.high < c.period) && (c.phase < c.period);
    endfunction

endpackage

// File: rtl/clk_pattern_gen_period_counter.sv
// rtl/clk_pattern_gen_period_counter.sv - free-running period counter with wrap detect and period tick
module period_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             period_tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        wrap   = run && (cnt_q == period - CNT_W'(1));
        cnt_d  = (run && !wrap) ? cnt_q + CNT_W'(1) : '0;
        tick_d = run && (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign cnt         = cnt_q;
    assign period_tick = tick_q;

endmodule

// File: rtl/clk_pattern_gen.sv
// rtl/clk_pattern_gen.sv - programmable clk_a / phase-delayed clk_b generator with shadowed config
module clk_pattern_gen
    import clk_pattern_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = DEF_PERIOD_C,
    parameter int DEF_HIGH   = DEF_HIGH_C,
    parameter int DEF_PHASE  = DEF_PHASE_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_phase,
    output logic             clk_a,
    output logic             clk_b,
    output logic             period_tick,
    output logic             cfg_err,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] act_period_q, act_period_d, act_high_q, act_high_d, act_phase_q, act_phase_d;
    logic [CNT_W-1:0] pend_period_q, pend_period_d, pend_high_q, pend_high_d, pend_phase_q, pend_phase_d;
    logic             pend_valid_q, pend_valid_d;
    logic             cfg_err_q, cfg_err_d;
    logic             b_armed_q, b_armed_d;
    logic             clk_a_q, clk_a_d, clk_b_q, clk_b_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic             run;
    logic [CNT_W:0]   cnt_b_sum, cnt_b;
    logic             arm_now;
    cfg_t             req;

    assign run = (state_q != IDLE);

    period_counter #(.CNT_W(CNT_W)) u_period_counter (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .period      (act_period_q),
        .cnt         (cnt),
        .wrap        (wrap),
        .period_tick (period_tick)
    );

    always_comb begin
        req.period = CFG_W'(cfg_period);
        req.high   = CFG_W'(cfg_high);
        req.phase  = CFG_W'(cfg_phase);

        act_period_d  = act_period_q;
        act_high_d    = act_high_q;
        act_phase_d   = act_phase_q;
        pend_period_d = pend_period_q;
        pend_high_d   = pend_high_q;
        pend_phase_d  = pend_phase_q;
        pend_valid_d  = pend_valid_q;
        cfg_err_d     = cfg_err_q;

        // Pending config only lands between periods so a period is never mixed
        if (pend_valid_q && (!run || wrap)) begin
            act_period_d = pend_period_q;
            act_high_d   = pend_high_q;
            act_phase_d  = pend_phase_q;
            pend_valid_d = 1'b0;
        end

        if (cfg_load) begin
            if (cfg_valid(req)) begin
                pend_period_d = cfg_period;
                pend_high_d   = cfg_high;
                pend_phase_d  = cfg_phase;
                pend_valid_d  = 1'b1;
                cfg_err_d     = 1'b0;
            end else begin
                cfg_err_d     = 1'b1;
            end
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = wrap ? IDLE : STOP;
            STOP:    if (en) state_d = RUN;
                     else if (wrap) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cnt_b_sum = {1'b0, cnt} + {1'b0, act_period_q} - {1'b0, act_phase_q};
        cnt_b     = (cnt_b_sum >= {1'b0, act_period_q}) ? cnt_b_sum - {1'b0, act_period_q} : cnt_b_sum;
        arm_now   = b_armed_q | (cnt == act_phase_q);

        clk_a_d   = 1'b0;
        clk_b_d   = 1'b0;
        b_armed_d = 1'b0;
        if (run && (state_d != IDLE)) begin
            clk_a_d   = (cnt < act_high_q);
            clk_b_d   = arm_now && (cnt_b < {1'b0, act_high_q});
            b_armed_d = arm_now;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            act_period_q  <= CNT_W'(DEF_PERIOD);
            act_high_q    <= CNT_W'(DEF_HIGH);
            act_phase_q   <= CNT_W'(DEF_PHASE);
            pend_period_q <= '0;
            pend_high_q   <= '0;
            pend_phase_q  <= '0;
            pend_valid_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
            b_armed_q     <= 1'b0;
            clk_a_q       <= 1'b0;
            clk_b_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            act_period_q  <= act_period_d;
            act_high_q    <= act_high_d;
            act_phase_q   <= act_phase_d;
            pend_period_q <= pend_period_d;
            pend_high_q   <= pend_high_d;
            pend_phase_q  <= pend_phase_d;
            pend_valid_q  <= pend_valid_d;
            cfg_err_q     <= cfg_err_d;
            b_armed_q     <= b_armed_d;
            clk_a_q       <= clk_a_d;
            clk_b_q       <= clk_b_d;
            busy_q        <= busy_d;
        end
    end

    assign clk_a   = clk_a_q;
    assign clk_b   = clk_b_q;
    assign cfg_err = cfg_err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_clk_pattern_gen.sv
// tb/tb_clk_pattern_gen.sv - scoreboard bench for clk_pattern_gen
module tb_clk_pattern_gen;

    logic       clk = 1'b0;
    logic       rst, en, cfg_load;
    logic [7:0] cfg_period, cfg_high, cfg_phase;
    logic       clk_a, clk_b, period_tick, cfg_err, busy;

    clk_pattern_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_load    (cfg_load),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_phase   (cfg_phase),
        .clk_a       (clk_a),
        .clk_b       (clk_b),
        .period_tick (period_tick),
        .cfg_err     (cfg_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] v;
        string      nm;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [4:0] Z = 5'b00000;
    localparam logic [4:0] B = 5'b00010;

    // Expected {clk_a, clk_b, period_tick, busy, cfg_err} at edge tt of a run segment
    function automatic logic [4:0] wave(input int tt, input int p, input int h, input int ph,
                                        input bit arm, input bit err);
        int   c;
        logic a, b;
        c = (tt - 1) % p;
        a = (c < h);
        if (arm) b = (((c - ph + p) % p) < h);
        else     b = ((tt - 1) >= ph) && ((((tt - 1 - ph) % p)) < h);
        return {a, b, (c == 0), 1'b1, err};
    endfunction

    task automatic step(input logic [4:0] v, input string nm, input int idx);
        exp_t e;
        @(posedge clk);
        e.v   = v;
        e.nm  = nm;
        e.idx = idx;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic set_cfg(input int p, input int h, input int ph);
        cfg_period = 8'(p);
        cfg_high   = 8'(h);
        cfg_phase  = 8'(ph);
        cfg_load   = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [4:0] act;
            e   = exp_q.pop_front();
            act = {clk_a, clk_b, period_tick, busy, cfg_err};
            n_tests++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s[%0d]: a/b/tick/busy/err got %b expected %b", e.nm, e.idx, act, e.v);
            end
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
        cfg_period = '0; cfg_high = '0; cfg_phase = '0;
        step(Z, "reset", 0);
        step(Z, "reset", 1);
        rst = 1'b0;
        step(Z, "idle", 0);
        step(Z, "idle", 1);

        en = 1'b1;
        step(B, "t1_start", 0);
        for (int t = 1; t <= 100; t++) step(wave(t, 10, 5, 5, 0, 0), "t1_default", t);
        rst = 1'b1; en = 1'b0;
        step(Z, "t1_reset", 0);
        rst = 1'b0;

        set_cfg(20, 8, 0);
        step(Z, "t2_load", 0);
        cfg_load = 1'b0;
        step(Z, "t2_apply", 0);
        en = 1'b1;
        step(B, "t2_start", 0);
        for (int t = 1; t <= 60; t++) step(wave(t, 20, 8, 0, 0, 0), "t2_duty40", t);
        rst = 1'b1; en = 1'b0;
        step(Z, "t2_reset", 0);
        rst = 1'b0;

        en = 1'b1;
        step(B, "t3_start", 0);
        for (int t = 1; t <= 12; t++) step(wave(t, 10, 5, 5, 0, 0), "t3_run", t);
        set_cfg(1, 1, 0);
        step(wave(13, 10, 5, 5, 0, 1), "t3_bad_period", 13);
        cfg_load = 1'b0;
        for (int t = 14; t <= 15; t++) step(wave(t, 10, 5, 5, 0, 1), "t3_err_hold", t);
        set_cfg(10, 10, 0);
        step(wave(16, 10, 5, 5, 0, 1), "t3_bad_high", 16);
        cfg_load = 1'b0;
        step(wave(17, 10, 5, 5, 0, 1), "t3_err_hold", 17);
        set_cfg(10, 5, 5);
        step(wave(18, 10, 5, 5, 0, 0), "t3_good_clears", 18);
        cfg_load = 1'b0;
        for (int t = 19; t <= 24; t++) step(wave(t, 10, 5, 5, 0, 0), "t3_run", t);

        set_cfg(6, 3, 2);
        step(wave(25, 10, 5, 5, 0, 0), "t4_load_cnt4", 25);
        cfg_load = 1'b0;
        for (int t = 26; t <= 30; t++) step(wave(t, 10, 5, 5, 0, 0), "t4_old_period", t);
        for (int s = 1; s <= 24; s++) step(wave(s, 6, 3, 2, 1, 0), "t4_new_period", s);
        rst = 1'b1; en = 1'b0;
        step(Z, "t4_reset", 0);
        rst = 1'b0;

        en = 1'b1;
        step(B, "t5_start", 0);
        for (int t = 1; t <= 22; t++) step(wave(t, 10, 5, 5, 0, 0), "t5_run", t);
        en = 1'b0;
        for (int t = 23; t <= 29; t++) step(wave(t, 10, 5, 5, 0, 0), "t5_stopping", t);
        step(Z, "t5_wrap_idle", 30);
        for (int i = 0; i < 12; i++) step(Z, "t5_idle", i);

        en = 1'b1;
        step(B, "t6_start", 0);
        for (int t = 1; t <= 5; t++) step(wave(t, 10, 5, 5, 0, 0), "t6_run", t);
        set_cfg(20, 8, 0);
        step(wave(6, 10, 5, 5, 0, 0), "t6_pending", 6);
        cfg_load = 1'b0;
        step(wave(7, 10, 5, 5, 0, 0), "t6_run", 7);
        rst = 1'b1;
        step(Z, "t6_reset_cnt7", 8);
        rst = 1'b0;
        step(B, "t6_restart", 0);
        for (int t = 1; t <= 25; t++) step(wave(t, 10, 5, 5, 0, 0), "t6_defaults", t);
        rst = 1'b1; en = 1'b0;
        step(Z, "t6_reset", 0);
        rst = 1'b0;

        set_cfg(10, 5, 10);
        step(5'b00001, "t7_bad_phase", 0);
        set_cfg(2, 1, 1);
        step(Z, "t7_min_load", 0);
        cfg_load = 1'b0;
        step(Z, "t7_apply", 0);
        en = 1'b1;
        step(B, "t7_start", 0);
        for (int t = 1; t <= 8; t++) step(wave(t, 2, 1, 1, 0, 0), "t7_period2", t);
        en = 1'b0;

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
